pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Parametrised PLL supervisor and reset sequencer for the iCE40 clocking front end. It runs on the always-stable reference clock and drives the PLL's active-low reset. It filters and supervises the PLL lock signal, retries the PLL when lock never arrives, and releases NUM_STAGES downstream synchronous resets in a fixed order. It sits between the PLL primitive wrapper and every reset consumer in the design.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles pll_resetb is held low per PLL reset attempt (≥1)
- LOCK_TIMEOUT, 65536: cycles to wait for lock before retrying the PLL (≥1)
- LOCK_FILTER, 1024: consecutive locked cycles required before release (≥1)
- NUM_STAGES, 3: number of sequenced reset outputs (1..8)
- STAGE_GAP, 16: cycles between successive stage releases (≥1)

Ports:
- clk  in  1  reference clock; free-running, independent of the PLL
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL LOCK, asynchronous to clk
- pll_resetb  out  1  to PLL RESETB, active low
- stage_reset  out  NUM_STAGES  per-stage reset, active high; bit 0 released first
- ready  out  1  high when all stages are released and lock is held
- lock_loss_count  out  8  lock drops seen in RELEASE or RUN; saturates at 255
- timeout_count  out  8  LOCK_TIMEOUT expiries; saturates at 255

## Operation
- pll_locked passes through a 2-FF synchronizer; locked_s is the synchronized value. All decisions use locked_s only.
- One shared counter cnt, width clog2(max(all cycle parameters))+1. It clears on every state transition.
- States and transitions:
  - PLL_RESET: pll_resetb=0, all stage_reset=1. When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_resetb=1.
    - If locked_s, go to FILTER.
    - Otherwise, when cnt==LOCK_TIMEOUT-1, go to PLL_RESET and increment timeout_count (saturating).
  - FILTER:
    - If !locked_s, go to WAIT_LOCK; the timeout restarts from 0.
    - When cnt==LOCK_FILTER-1, go to RELEASE with stage index idx=0.
  - RELEASE: when cnt==STAGE_GAP-1, clear stage_reset[idx], increment idx and clear cnt. The release of idx==NUM_STAGES-1 moves to RUN and sets ready.
  - RUN: steady state. All outputs hold.
- Lock loss (!locked_s) in RELEASE or RUN:
  - On the next edge, all stage_reset bits return to 1 and ready goes to 0.
  - lock_loss_count increments (saturating) and the state goes to WAIT_LOCK. The PLL is not reset; the timeout covers a PLL that does not recover.
- Counters clear only on reset.

## Timing
- Reset values: state=PLL_RESET, pll_resetb=0, stage_reset=all 1, ready=0, both counts=0, idx=0, cnt=0, synchronizer flops=0.
- All outputs are registered. No combinational path exists from pll_locked to any output.
- Lock path latency:
  - The synchronizer adds 2 cycles.
  - With FILTER first occupied at cycle T, RELEASE begins at T+LOCK_FILTER.
  - stage_reset[k] falls at T+LOCK_FILTER+(k+1)·STAGE_GAP.
  - ready rises on the same edge as the last stage release.
- Lock loss latency: stage_reset asserts at most 3 clk after pll_locked falls (2 synchronizer + 1 register).
- Simultaneous events:
  - Lock loss on the cycle a stage would release takes precedence; no bit is cleared.
  - locked_s rising on the same cycle as timeout expiry in WAIT_LOCK goes to FILTER with no timeout counted.
- reset mid-operation returns every register to its reset value on the next edge, regardless of state.
- Saturating counters hold at 255 and never wrap.

## Structure
- Shared package clkrst_pkg holds:
  - the state encoding constants (PLL_RESET, WAIT_LOCK, FILTER, RELEASE, RUN; 3 bits);
  - the counter-width helper function;
  - the saturation limit 8'hFF.
- Sub-module sync_2ff (1-bit, reset to 0) synchronizes pll_locked; it is reusable for other async inputs.
- The main FSM, counter and stage register stay in pll_reset_seq.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_FILTER=8, NUM_STAGES=3, STAGE_GAP=2, with reset released before edge 0.
- pll_locked held high from start:
  - pll_resetb is low for edges 0–3 and high from edge 4.
  - stage_reset goes 3'b110@15, 3'b100@17, 3'b000@19; ready=1@19.
- pll_locked held low: PLL_RESET re-entered at edge 68 with pll_resetb=0 and timeout_count=1; it reaches 2 at edge 136.
- Lock glitch low for 1 cycle at filter count 5: state returns to WAIT_LOCK, and release is delayed by a full new LOCK_FILTER window. lock_loss_count stays 0.
- pll_locked drops in RUN: stage_reset=3'b111 and ready=0 within 3 edges, lock_loss_count=1. Relock replays the full sequence.
- 300 lock drops in RUN: lock_loss_count reads 255 and never wraps.
- reset asserted mid-RELEASE (after stage 0 released): the next edge shows all reset values and pll_resetb=0.

Source files
------------

// File: rtl/clkrst_pkg.sv
// rtl/clkrst_pkg.sv - shared state encoding, counter sizing and saturation limit for the clock/reset front end
package clkrst_pkg;

    localparam logic [2:0] PLL_RESET = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] FILTER    = 3'd2;
    localparam logic [2:0] RELEASE   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // One extra bit so the largest terminal value always fits.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input, resets to 0
module sync_2ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock supervisor with retry and ordered release of downstream resets
module pll_reset_seq
    import clkrst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_FILTER    = 1024,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  pll_resetb,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  ready,
    output logic [7:0]            lock_loss_count,
    output logic [7:0]            timeout_count
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, STAGE_GAP);
    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic                  locked_s;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  resetb_q, resetb_d;
    logic [7:0]            loss_q, loss_d;
    logic [7:0]            tout_q, tout_d;

    sync_2ff u_lock_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (pll_locked),
        .q_o     (locked_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        stage_d  = stage_q;
        ready_d  = ready_q;
        resetb_d = resetb_q;
        loss_d   = loss_q;
        tout_d   = tout_q;

        case (state_q)
            PLL_RESET: begin
                resetb_d = 1'b0;
                stage_d  = '1;
                ready_d  = 1'b0;
                if (cnt_q == RST_LAST) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    resetb_d = 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Lock arriving on the expiry cycle wins; no timeout is counted.
                if (locked_s) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = PLL_RESET;
                    cnt_d    = '0;
                    resetb_d = 1'b0;
                    tout_d   = (tout_q == SAT_MAX) ? tout_q : tout_q + 8'd1;
                end
            end
            FILTER: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            RELEASE, RUN: begin
                // Lock loss is checked first so a pending stage release is dropped.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    stage_d = '1;
                    ready_d = 1'b0;
                    loss_d  = (loss_q == SAT_MAX) ? loss_q : loss_q + 8'd1;
                end else if (state_q == RUN) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (k == int'(idx_q)) stage_d[k] = 1'b0;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = PLL_RESET;
                cnt_d    = '0;
                stage_d  = '1;
                ready_d  = 1'b0;
                resetb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLL_RESET;
            cnt_q    <= '0;
            idx_q    <= '0;
            stage_q  <= '1;
            ready_q  <= 1'b0;
            resetb_q <= 1'b0;
            loss_q   <= 8'd0;
            tout_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            ready_q  <= ready_d;
            resetb_q <= resetb_d;
            loss_q   <= loss_d;
            tout_q   <= tout_d;
        end
    end

    assign pll_resetb      = resetb_q;
    assign stage_reset     = stage_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;
    assign timeout_count   = tout_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq with directed lock/timeout/reset scenarios
module tb_pll_reset_seq;

    localparam int K_RSTB  = 0;
    localparam int K_STAGE = 1;
    localparam int K_READY = 2;
    localparam int K_LOSS  = 3;
    localparam int K_TOUT  = 4;

    typedef struct {
        int at;
        int kind;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_resetb;
    logic [2:0] stage_reset;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (64),
        .LOCK_FILTER    (8),
        .NUM_STAGES     (3),
        .STAGE_GAP      (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_resetb      (pll_resetb),
        .stage_reset     (stage_reset),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .timeout_count   (timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample at the falling edge; "@n" is the value visible just before edge n.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            int   got;
            string nm;
            e = sb.pop_front();
            case (e.kind)
                K_RSTB:  begin got = int'(pll_resetb);      nm = "pll_resetb";      end
                K_STAGE: begin got = int'(stage_reset);     nm = "stage_reset";     end
                K_READY: begin got = int'(ready);           nm = "ready";           end
                K_LOSS:  begin got = int'(lock_loss_count); nm = "lock_loss_count"; end
                default: begin got = int'(timeout_count);   nm = "timeout_count";   end
            endcase
            n_vec++;
            if (e.at != cyc || got != e.val) begin
                n_bad++;
                $display("FAIL %s @%0d (sampled @%0d): got %0d expected %0d",
                         nm, e.at - base, cyc - base, got, e.val);
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic go_until(input int n);
        while (cyc < base + n) wait_edge();
    endtask

    task automatic do_reset(input logic lock);
        pll_locked = lock;
        reset = 1'b1;
        repeat (2) wait_edge();
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic expect_at(input int n, input int kind, input int val);
        sb.push_back('{base + n, kind, val});
    endtask

    task automatic flush(input string scn);
        if (sb.size() != 0) begin
            $display("FAIL %s: %0d expectations never reached, required 0", scn, sb.size());
            n_vec += sb.size();
            n_bad += sb.size();
            sb.delete();
        end
    endtask

    initial begin
        // Lock from start, release order, then loss in RUN and relock.
        do_reset(1'b1);
        expect_at(0, K_RSTB, 0);   expect_at(0, K_STAGE, 7);  expect_at(0, K_READY, 0);
        expect_at(0, K_LOSS, 0);   expect_at(0, K_TOUT, 0);
        expect_at(3, K_RSTB, 0);   expect_at(4, K_RSTB, 1);
        expect_at(14, K_STAGE, 7); expect_at(15, K_STAGE, 6); expect_at(17, K_STAGE, 4);
        expect_at(18, K_STAGE, 4); expect_at(18, K_READY, 0);
        expect_at(19, K_STAGE, 0); expect_at(19, K_READY, 1);
        expect_at(27, K_STAGE, 0); expect_at(27, K_READY, 1);
        expect_at(28, K_STAGE, 7); expect_at(28, K_READY, 0); expect_at(28, K_LOSS, 1);
        expect_at(28, K_RSTB, 1);
        expect_at(46, K_STAGE, 4); expect_at(46, K_READY, 0);
        expect_at(47, K_STAGE, 0); expect_at(47, K_READY, 1); expect_at(47, K_LOSS, 1);
        go_until(25); pll_locked = 1'b0;
        go_until(30); pll_locked = 1'b1;
        go_until(50); flush("lock_run");

        // No lock: repeated timeouts.
        do_reset(1'b0);
        expect_at(0, K_RSTB, 0);   expect_at(4, K_RSTB, 1);
        expect_at(67, K_RSTB, 1);  expect_at(67, K_TOUT, 0);
        expect_at(68, K_RSTB, 0);  expect_at(68, K_TOUT, 1);
        expect_at(72, K_RSTB, 1);
        expect_at(135, K_TOUT, 1); expect_at(136, K_TOUT, 2); expect_at(136, K_RSTB, 0);
        go_until(140); flush("timeout");

        // Lock arrives on the timeout expiry cycle.
        do_reset(1'b0);
        expect_at(67, K_RSTB, 1);  expect_at(68, K_RSTB, 1);  expect_at(68, K_TOUT, 0);
        expect_at(77, K_STAGE, 7); expect_at(78, K_STAGE, 6);
        go_until(65); pll_locked = 1'b1;
        go_until(80); flush("lock_at_expiry");

        // One-cycle glitch at filter count 5.
        do_reset(1'b1);
        expect_at(15, K_STAGE, 7); expect_at(21, K_STAGE, 7); expect_at(22, K_STAGE, 6);
        expect_at(25, K_READY, 0); expect_at(26, K_STAGE, 0); expect_at(26, K_READY, 1);
        expect_at(26, K_LOSS, 0);
        go_until(8); pll_locked = 1'b0;
        go_until(9); pll_locked = 1'b1;
        go_until(30); flush("filter_glitch");

        // Loss on the edge stage 0 would release.
        do_reset(1'b1);
        expect_at(14, K_STAGE, 7); expect_at(14, K_LOSS, 0);
        expect_at(15, K_STAGE, 7); expect_at(15, K_READY, 0); expect_at(15, K_LOSS, 1);
        go_until(12); pll_locked = 1'b0;
        go_until(20); flush("loss_at_release");

        // 300 drops in RUN, then reset during RELEASE.
        do_reset(1'b1);
        for (int j = 0; j < 300; j++) begin
            expect_at(20 + 26 * j + 3, K_LOSS, (j + 1 > 255) ? 255 : j + 1);
            if (j == 0 || j == 299) expect_at(20 + 26 * j + 3, K_STAGE, 7);
        end
        expect_at(7834, K_STAGE, 6); expect_at(7834, K_LOSS, 255);
        expect_at(7835, K_RSTB, 0);  expect_at(7835, K_STAGE, 7); expect_at(7835, K_READY, 0);
        expect_at(7835, K_LOSS, 0);  expect_at(7835, K_TOUT, 0);
        for (int j = 0; j <= 300; j++) begin
            go_until(20 + 26 * j);     pll_locked = 1'b0;
            go_until(20 + 26 * j + 1); pll_locked = 1'b1;
        end
        go_until(7834); reset = 1'b1;
        go_until(7837); flush("saturate_and_reset");
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
